// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared run-logger types and default widths.
package seq_det_pkg;
  localparam int TS_W_DEF = 16;
  localparam int LEN_W_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef enum logic {IDLE, RUN} run_state_t;
  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [LEN_W_DEF-1:0] len;
  } run_evt_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; push on full is allowed when a pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // last popped word is shown while empty so the outputs hold their value
  assign data_o  = empty_o ? last_q : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i) if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/match_run_logger.sv
// match_run_logger: collapses runs of match strobes into {start ts, length} events in a FIFO.
module match_run_logger
  import seq_det_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             match_in_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [TS_W-1:0]  evt_ts_o,
  output logic [LEN_W-1:0] evt_len_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             overflow_o,
  input  logic             ovf_clr_i
);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  run_state_t state_q, state_d;
  logic [TS_W-1:0] ts_q, start_q, start_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] mcnt_q, dcnt_q;
  logic ovf_q, push, pop, drop, full, empty;
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    len_d   = len_q;
    push    = 1'b0;
    if (state_q == IDLE) begin
      if (match_in_i) begin
        state_d = RUN;
        start_d = ts_q;
        len_d   = LEN_W'(1);
      end
    end else if (!match_in_i) begin
      push    = 1'b1;
      state_d = IDLE;
    end else if (len_q == LEN_MAX) begin
      push    = 1'b1;
      start_d = ts_q;
      len_d   = LEN_W'(1);
    end else begin
      len_d = len_q + 1'b1;
    end
  end
  assign pop  = !empty && evt_ready_i;
  assign drop = push && full && !pop;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ts_q    <= '0;
      start_q <= '0;
      len_q   <= '0;
      mcnt_q  <= '0;
      dcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 1'b1;
      start_q <= start_d;
      len_q   <= len_d;
      mcnt_q  <= mcnt_q + CNT_W'(match_in_i && !(&mcnt_q));
      dcnt_q  <= dcnt_q + CNT_W'(drop && !(&dcnt_q));
      ovf_q   <= drop || (ovf_q && !ovf_clr_i);
    end
  end
  sync_fifo #(.WIDTH(TS_W + LEN_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (push),
    .data_i ({start_q, len_q}),
    .pop_i  (pop),
    .data_o ({evt_ts_o, evt_len_o}),
    .full_o (full),
    .empty_o(empty)
  );
  assign evt_valid_o   = !empty;
  assign match_count_o = mcnt_q;
  assign drop_count_o  = dcnt_q;
  assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_match_run_logger.sv
// tb_match_run_logger: directed scenarios plus random traffic checked against an event-queue model.
module tb_match_run_logger;
  localparam int TS_W = 6, LEN_W = 3, DEPTH = 8, CNT_W = 8;
  localparam int MAX = (1 << LEN_W) - 1, TSM = 1 << TS_W, CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, reset = 1'b1, match = 1'b0, ready = 1'b0, clr = 1'b0;
  logic evt_valid, overflow;
  logic [TS_W-1:0] evt_ts;
  logic [LEN_W-1:0] evt_len;
  logic [CNT_W-1:0] mcnt, dcnt;
  typedef struct {int ts; int len;} ev_t;
  ev_t q[$];
  ev_t last;
  int ts, n, bts, mc, dc, errs, checks;
  bit ov, armed;
  match_run_logger #(.TS_W(TS_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .match_in_i(match), .evt_valid_o(evt_valid),
    .evt_ready_i(ready), .evt_ts_o(evt_ts), .evt_len_o(evt_len),
    .match_count_o(mcnt), .drop_count_o(dcnt), .overflow_o(overflow), .ovf_clr_i(clr)
  );
  always #5 clk = ~clk;
  // model: a run of n matches splits into MAX-long chunks, the remainder emitted when it ends
  always @(posedge clk) begin : model
    ev_t e;
    bit have, dropped;
    int k;
    if (reset) begin
      q.delete();
      last = '{0, 0};
      ts = 0; n = 0; bts = 0; mc = 0; dc = 0; ov = 0; armed = 1;
    end else begin
      have = 0; dropped = 0; e = '{0, 0};
      if (match) begin
        n++;
        if (n == 1) bts = ts;
        if (mc < CMAX) mc++;
        if (n > 1 && (n - 1) % MAX == 0) begin
          have = 1;
          e = '{(bts + n - 1 - MAX) % TSM, MAX};
        end
      end else if (n > 0) begin
        k = (n - 1) / MAX;
        have = 1;
        e = '{(bts + MAX * k) % TSM, n - MAX * k};
        n = 0;
      end
      if (ready && q.size() > 0) last = q.pop_front();
      if (have) begin
        if (q.size() < DEPTH) q.push_back(e);
        else begin
          dropped = 1;
          if (dc < CMAX) dc++;
        end
      end
      ov = dropped ? 1'b1 : (clr ? 1'b0 : ov);
      ts = (ts + 1) % TSM;
    end
  end
  always @(negedge clk) begin : compare
    bit ev;
    int ets, elen;
    if (armed) begin
      ev = q.size() > 0;
      ets = ev ? q[0].ts : last.ts;
      elen = ev ? q[0].len : last.len;
      checks++;
      if (evt_valid !== ev || evt_ts !== TS_W'(ets) || evt_len !== LEN_W'(elen) ||
          mcnt !== CNT_W'(mc) || dcnt !== CNT_W'(dc) || overflow !== ov) begin
        errs++;
        $display("FAIL cycle_cmp t=%0t dut v=%0b ts=%0d len=%0d mc=%0d dc=%0d ov=%0b exp v=%0b ts=%0d len=%0d mc=%0d dc=%0d ov=%0b",
                 $time, evt_valid, evt_ts, evt_len, mcnt, dcnt, overflow, ev, ets, elen, mc, dc, ov);
      end
    end
  end
  task automatic cy(input bit m, input bit r, input bit c);
    match = m; ready = r; clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cy(0, 0, 0);
    reset = 1'b0;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  initial begin
    int p, pr;
    cy(0, 0, 0);
    do_reset();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_ts", 32'(evt_ts), 0);
    chk("rst_len", 32'(evt_len), 0);
    chk("rst_mc", 32'(mcnt), 0);
    chk("rst_dc", 32'(dcnt), 0);
    chk("rst_ov", 32'(overflow), 0);
    repeat (5) cy(0, 0, 0);
    cy(1, 0, 0);
    cy(0, 0, 0);
    chk("single_valid", 32'(evt_valid), 1);
    chk("single_ts", 32'(evt_ts), 5);
    chk("single_len", 32'(evt_len), 1);
    chk("single_mc", 32'(mcnt), 1);
    cy(0, 1, 0);
    chk("single_pop", 32'(evt_valid), 0);
    chk("single_hold_ts", 32'(evt_ts), 5);
    repeat (2) cy(0, 1, 0);
    repeat (4) cy(1, 1, 0);
    cy(0, 1, 0);
    chk("overlap_ts", 32'(evt_ts), 10);
    chk("overlap_len", 32'(evt_len), 4);
    chk("overlap_mc", 32'(mcnt), 5);
    cy(0, 1, 0);
    do_reset();
    repeat (16) cy(1, 0, 0);
    cy(0, 0, 0);
    chk("cap0_ts", 32'(evt_ts), 0);
    chk("cap0_len", 32'(evt_len), 7);
    chk("cap_mc", 32'(mcnt), 16);
    cy(0, 1, 0);
    chk("cap1_ts", 32'(evt_ts), 7);
    chk("cap1_len", 32'(evt_len), 7);
    cy(0, 1, 0);
    chk("cap2_ts", 32'(evt_ts), 14);
    chk("cap2_len", 32'(evt_len), 2);
    cy(0, 1, 0);
    chk("cap_empty", 32'(evt_valid), 0);
    do_reset();
    repeat (10) begin cy(1, 0, 0); cy(0, 0, 0); end
    chk("ovf_dc", 32'(dcnt), 2);
    chk("ovf_flag", 32'(overflow), 1);
    cy(0, 0, 1);
    chk("ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_ts", 32'(evt_ts), 32'(2 * i));
      cy(0, 1, 0);
    end
    chk("ovf_drained", 32'(evt_valid), 0);
    do_reset();
    repeat (8) begin cy(1, 0, 0); cy(0, 0, 0); end
    cy(1, 0, 0);
    cy(0, 1, 0);
    chk("full_pp_dc", 32'(dcnt), 0);
    chk("full_pp_ov", 32'(overflow), 0);
    chk("full_pp_head", 32'(evt_ts), 2);
    do_reset();
    cy(1, 0, 0);
    cy(1, 0, 0);
    reset = 1'b1;
    cy(1, 0, 0);
    reset = 1'b0;
    chk("midrst_valid", 32'(evt_valid), 0);
    chk("midrst_mc", 32'(mcnt), 0);
    cy(0, 0, 0);
    chk("midrst_noevt", 32'(evt_valid), 0);
    do_reset();
    repeat (63) cy(0, 0, 0);
    repeat (2) cy(1, 0, 0);
    cy(0, 0, 0);
    cy(1, 0, 0);
    cy(0, 0, 0);
    chk("wrap_ts", 32'(evt_ts), 63);
    chk("wrap_len", 32'(evt_len), 2);
    cy(0, 1, 0);
    chk("wrap_next_ts", 32'(evt_ts), 2);
    for (int ph = 0; ph < 4; ph++) begin
      p  = ph == 2 ? 85 : 50;
      pr = ph == 1 ? 3 : (ph == 2 ? 90 : 50);
      for (int i = 0; i < 1500; i++) begin
        reset = ph == 3 && $urandom_range(0, 299) == 0;
        cy($urandom_range(0, 99) < p, $urandom_range(0, 99) < pr, $urandom_range(0, 49) == 0);
        reset = 1'b0;
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
